// File: rtl/vga_pixel_sink.sv
// vga_pixel_sink: receiving end of the pixel-plot interface.
// Registers and bounds-checks incoming pixels, converts (X,Y) to a linear
// framebuffer address, buffers them in a show-ahead FIFO and drains them to
// a stallable framebuffer write port. A built-in clear engine fills the
// whole screen with one colour.
// Optional build macro VGA_PIXEL_SINK_STATS_EN adds a saturating 16-bit
// drop_count output counting pixels lost to a full FIFO.
module vga_pixel_sink #(
  parameter int H_RES      = 320,
  parameter int V_RES      = 240,
  parameter int FIFO_DEPTH = 8,
  parameter int COLOR_W    = 3,
  parameter int ADDR_W     = 17
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               plot,
  input  logic [8:0]         X,
  input  logic [7:0]         Y,
  input  logic [COLOR_W-1:0] color,
  input  logic               clear_req,
  input  logic [COLOR_W-1:0] clear_color,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_data,
  input  logic               mem_ready,
  output logic               busy,
  output logic               clear_done,
`ifdef VGA_PIXEL_SINK_STATS_EN
  output logic [15:0]        drop_count,
`endif
  output logic               overflow
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + COLOR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Stage 1: bounds check and address conversion
  // ---------------------------------------------------------------------
  logic              in_range;
  logic [ADDR_W-1:0] addr_calc;
  logic              s1_valid_q;
  logic [ADDR_W-1:0] s1_addr_q;
  logic [COLOR_W-1:0] s1_color_q;

  assign in_range  = (32'(X) < 32'(H_RES)) && (32'(Y) < 32'(V_RES));
  // Computed at full address width so in-range inputs never truncate.
  assign addr_calc = ADDR_W'(Y) * ADDR_W'(H_RES) + ADDR_W'(X);

  // Capture the incoming pixel; out-of-range pixels simply never become valid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_color_q <= '0;
    end else begin
      s1_valid_q <= plot && in_range;
      s1_addr_q  <= addr_calc;
      s1_color_q <= color;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: show-ahead pixel FIFO
  // ---------------------------------------------------------------------
  logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             drop;
  logic             pop;
  logic [ENT_W-1:0] head;

  state_t            state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic [COLOR_W-1:0] clr_color_q;

  assign fifo_empty = (count_q == '0);
  // Fullness is judged before any same-edge pop, so a pop never makes room.
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign push       = s1_valid_q && !fifo_full;
  assign drop       = s1_valid_q && fifo_full;
  assign pop        = (state_q == IDLE) && !fifo_empty && mem_ready;
  assign head       = fifo_mem[rd_ptr_q];

  // Next-state pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr_q] <= {s1_addr_q, s1_color_q};
  end

  // FIFO pointer and occupancy registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ---------------------------------------------------------------------
  // Write-port control FSM and clear engine
  // ---------------------------------------------------------------------
  // Sequences IDLE (FIFO drain) / CLEAR (screen sweep) / DONE (pulse).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      clr_cnt_q   <= '0;
      clr_color_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clear_req) begin
            state_q     <= CLEAR;
            clr_cnt_q   <= '0;
            clr_color_q <= clear_color;
          end
        end
        CLEAR: begin
          if (mem_ready) begin
            if (clr_cnt_q == LAST_ADDR) state_q <= DONE;
            else                        clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Write port is driven straight from the FIFO head or the clear counter,
  // so a stalled write holds its address/data until accepted.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    if (state_q == CLEAR) begin
      mem_we   = 1'b1;
      mem_addr = clr_cnt_q;
      mem_data = clr_color_q;
    end else if ((state_q == IDLE) && !fifo_empty) begin
      mem_we   = 1'b1;
      mem_addr = head[ENT_W-1:COLOR_W];
      mem_data = head[COLOR_W-1:0];
    end
  end

  assign clear_done = (state_q == DONE);
  assign busy       = s1_valid_q || !fifo_empty || (state_q != IDLE);

  // Sticky overflow flag: only pixels lost to a full FIFO set it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)     overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
  end

`ifdef VGA_PIXEL_SINK_STATS_EN
  // Saturating count of pixels lost to a full FIFO.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                              drop_count <= '0;
    else if (drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_vga_pixel_sink.sv
// Directed testbench for vga_pixel_sink: single pixel, bounds, FIFO overflow,
// full-screen clear with a pixel plotted during it, and reset mid-clear.
module tb_vga_pixel_sink;
  localparam int COLOR_W = 3;
  localparam int ADDR_W  = 17;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               plot = 1'b0;
  logic [8:0]         X = '0;
  logic [7:0]         Y = '0;
  logic [COLOR_W-1:0] color = '0;
  logic               clear_req = 1'b0;
  logic [COLOR_W-1:0] clear_color = '0;
  logic               mem_ready = 1'b0;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [COLOR_W-1:0] mem_data;
  logic               busy;
  logic               clear_done;
  logic               overflow;
`ifdef VGA_PIXEL_SINK_STATS_EN
  logic [15:0]        drop_count;
`endif

  vga_pixel_sink dut (
    .clock       (clock),
    .reset       (reset),
    .plot        (plot),
    .X           (X),
    .Y           (Y),
    .color       (color),
    .clear_req   (clear_req),
    .clear_color (clear_color),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_ready   (mem_ready),
    .busy        (busy),
    .clear_done  (clear_done),
`ifdef VGA_PIXEL_SINK_STATS_EN
    .drop_count  (drop_count),
`endif
    .overflow    (overflow)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int done_pulses = 0;
  logic [ADDR_W-1:0]  wq_addr [$];
  logic [COLOR_W-1:0] wq_data [$];

  // Record every completed framebuffer write.
  always @(posedge clock) begin
    if (!reset && mem_we && mem_ready) begin
      wq_addr.push_back(mem_addr);
      wq_data.push_back(mem_data);
    end
  end

  // Count clear_done pulses.
  always @(negedge clock) begin
    if (clear_done) done_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  int n0, n1, bad;
  bit found;

  initial begin
    // Reset values
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_we",       32'(mem_we), 32'd0);
    check("rst_addr",     32'(mem_addr), 32'd0);
    check("rst_data",     32'(mem_data), 32'd0);
    check("rst_busy",     32'(busy), 32'd0);
    check("rst_done",     32'(clear_done), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    tick();
    reset = 1'b0;

    // Single pixel (5,2) colour 3 -> address 645, write in cycle 2 only
    mem_ready = 1'b1;
    plot = 1'b1; X = 9'd5; Y = 8'd2; color = 3'd3;
    tick();
    plot = 1'b0;
    @(negedge clock);
    check("px_c1_we",   32'(mem_we), 32'd0);
    check("px_c1_busy", 32'(busy), 32'd1);
    @(negedge clock);
    check("px_c2_we",   32'(mem_we), 32'd1);
    check("px_c2_addr", 32'(mem_addr), 32'd645);
    check("px_c2_data", 32'(mem_data), 32'd3);
    @(negedge clock);
    check("px_c3_we",   32'(mem_we), 32'd0);
    check("px_c3_busy", 32'(busy), 32'd0);
    check("px_nwrites", 32'(wq_addr.size()), 32'd1);

    // Out-of-range pixels are silently dropped
    tick();
    n0 = wq_addr.size();
    plot = 1'b1; X = 9'd320; Y = 8'd0; color = 3'd1;
    tick();
    X = 9'd0; Y = 8'd240;
    tick();
    plot = 1'b0;
    repeat (4) tick();
    check("oor_nwrites", 32'(wq_addr.size() - n0), 32'd0);
    check("oor_overflow", 32'(overflow), 32'd0);
    plot = 1'b1; X = 9'd319; Y = 8'd239; color = 3'd7;
    tick();
    plot = 1'b0;
    repeat (4) tick();
    check("corner_nwrites", 32'(wq_addr.size() - n0), 32'd1);
    check("corner_addr", 32'(wq_addr[n0]), 32'd76799);
    check("corner_data", 32'(wq_data[n0]), 32'd7);

    // Stalled port: 12 pixels, 8 buffered, 4 dropped
    mem_ready = 1'b0;
    n0 = wq_addr.size();
    for (int i = 0; i < 12; i++) begin
      plot = 1'b1; X = 9'(i); Y = 8'd1; color = 3'(i);
      tick();
    end
    plot = 1'b0;
    repeat (3) tick();
    @(negedge clock);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_we_held", 32'(mem_we), 32'd1);
    check("ovf_head_addr", 32'(mem_addr), 32'd320);
    check("ovf_busy", 32'(busy), 32'd1);
    check("ovf_no_writes", 32'(wq_addr.size() - n0), 32'd0);
`ifdef VGA_PIXEL_SINK_STATS_EN
    check("ovf_drop_count", 32'(drop_count), 32'd4);
`endif
    tick();
    mem_ready = 1'b1;
    repeat (12) tick();
    check("drain_nwrites", 32'(wq_addr.size() - n0), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d_addr", i), 32'(wq_addr[n0+i]), 32'(320 + i));
      check($sformatf("drain%0d_data", i), 32'(wq_data[n0+i]), 32'(i % 8));
    end

    // Full-screen clear with colour 5, pixel (10,10,2) plotted mid-clear
    n0 = wq_addr.size();
    done_pulses = 0;
    clear_color = 3'd5; clear_req = 1'b1;
    tick();
    clear_req = 1'b0; clear_color = 3'd0;
    repeat (20) tick();
    plot = 1'b1; X = 9'd10; Y = 8'd10; color = 3'd2;
    tick();
    plot = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 80000; k++) begin
      @(negedge clock);
      if (clear_done) begin
        found = 1'b1;
        break;
      end
    end
    check("clr_done_seen", 32'(found), 32'd1);
    check("clr_nwrites", 32'(wq_addr.size() - n0), 32'd76800);
    check("clr_done_we", 32'(mem_we), 32'd0);
    @(negedge clock);
    check("clr_done_once", 32'(clear_done), 32'd0);
    check("late_px_we", 32'(mem_we), 32'd1);
    check("late_px_addr", 32'(mem_addr), 32'd3210);
    check("late_px_data", 32'(mem_data), 32'd2);
    @(negedge clock);
    check("clr_busy_end", 32'(busy), 32'd0);
    check("clr_pulses", 32'(done_pulses), 32'd1);
    bad = 0;
    for (int i = 0; i < 76800; i++) begin
      if ((n0 + i) < wq_addr.size()) begin
        if (wq_addr[n0+i] != ADDR_W'(i) || wq_data[n0+i] != 3'd5) bad++;
      end else begin
        bad++;
      end
    end
    check("clr_sweep_errors", 32'(bad), 32'd0);
    check("clr_total_writes", 32'(wq_addr.size() - n0), 32'd76801);
    if (wq_addr.size() > n0 + 76800) begin
      check("post_clr_addr", 32'(wq_addr[n0+76800]), 32'd3210);
      check("post_clr_data", 32'(wq_data[n0+76800]), 32'd2);
    end

    // Reset asserted at clear address 1000
    tick();
    n0 = wq_addr.size();
    clear_color = 3'd6; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clock);
      if (mem_addr == ADDR_W'(1000)) begin
        found = 1'b1;
        break;
      end
    end
    check("rc_reach_1000", 32'(found), 32'd1);
    reset = 1'b1;
    #1;
    check("rc_we_now", 32'(mem_we), 32'd0);
    check("rc_busy_now", 32'(busy), 32'd0);
    check("rc_addr_now", 32'(mem_addr), 32'd0);
    check("rc_overflow", 32'(overflow), 32'd0);
    n1 = wq_addr.size();
    check("rc_writes_before", 32'(n1 - n0), 32'd1000);
    tick();
    reset = 1'b0;
    repeat (20) tick();
    check("rc_no_writes", 32'(wq_addr.size() - n1), 32'd0);
    check("rc_busy_after", 32'(busy), 32'd0);
    check("rc_we_after", 32'(mem_we), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
